// File: rtl/rgst_pipe.sv
// Elastic pipeline register: DEPTH load/clear stages with valid/ready at both ends.
// Empty stages refill even while the output is stalled, so bubbles collapse toward q.
module rgst_pipe #(
  parameter int              DW      = 16,
  parameter int              DEPTH   = 4,
  parameter logic [DW-1:0]   CLR_VAL = {DW{1'b0}},
  localparam int             OW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          clr,
  input  logic [DW-1:0] d,
  input  logic          d_vld,
  output logic          d_rdy,
  output logic [DW-1:0] q,
  output logic          q_vld,
  input  logic          q_rdy,
  output logic [OW-1:0] occ
);

  // Handshake: a beat moves when valid & ready are both high on a rising edge.
  // d_vld must not depend on d_rdy; q_rdy may depend on q_vld. clr forces both
  // d_rdy and q_vld low, so a flush cycle never transfers anything.

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] en;
  logic [DEPTH-1:0] in_vld;
  logic [DW-1:0]    data   [DEPTH];
  logic [DW-1:0]    in_dat [DEPTH];
  logic             all_full;
  logic             in_xfer;
  logic             out_xfer;

  // en[i] is high when some stage at or after i is empty, or the output drains.
  // Built as a running AND from the output side to avoid a self-referencing vector.
  always_comb begin
    all_full = 1'b1;
    en       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      all_full = all_full & vld[i];
      en[i]    = q_rdy | ~all_full;
    end
  end

  always_comb begin
    in_vld    = '0;
    in_vld[0] = d_vld;
    for (int k = 0; k < DEPTH; k++) begin
      in_dat[k] = d;
    end
    for (int i = 1; i < DEPTH; i++) begin
      in_vld[i] = vld[i-1];
      in_dat[i] = data[i-1];
    end
  end

  assign d_rdy    = en[0] & ~clr;
  assign q_vld    = vld[DEPTH-1] & ~clr;
  assign q        = data[DEPTH-1];
  assign in_xfer  = d_vld & d_rdy;
  assign out_xfer = q_vld & q_rdy;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vld <= '0;
      occ <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data[i] <= CLR_VAL;
      end
    end else if (clr) begin
      vld <= '0;
      occ <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data[i] <= CLR_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (en[i]) begin
          vld[i] <= in_vld[i];
          // Data only loads with a valid beat; a bubble leaves the old value in place.
          if (in_vld[i]) begin
            data[i] <= in_dat[i];
          end
        end
      end
      occ <= occ + OW'(in_xfer) - OW'(out_xfer);
    end
  end

endmodule

// File: tb/tb_rgst_pipe.sv
// Bench for rgst_pipe: directed scenarios on DEPTH=4 plus random traffic on DEPTH=4/1/7,
// each instance shadowed by an item/position model of the pipe.
module tb_rgst_pipe;

  localparam int NI = 3;

  logic        clk;
  logic        rst_b;
  logic        clr;
  logic [15:0] d_a   [NI];
  logic        dv_a  [NI];
  logic        qr_a  [NI];
  logic [15:0] q_a   [NI];
  logic        qv_a  [NI];
  logic        dr_a  [NI];
  logic [31:0] occ_a [NI];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int D  = (gi == 0) ? 4 : (gi == 1) ? 1 : 7;
    localparam int OW = $clog2(D + 1);

    logic [OW-1:0] occ_w;
    logic [15:0]   exp_q [$];
    int            pos_q [$];
    int            np    [$];
    logic          out_x;
    logic          in_x;
    logic          exp_qv;
    logic          exp_dr;

    rgst_pipe #(.DW(16), .DEPTH(D), .CLR_VAL(16'h0000)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .clr   (clr),
      .d     (d_a[gi]),
      .d_vld (dv_a[gi]),
      .d_rdy (dr_a[gi]),
      .q     (q_a[gi]),
      .q_vld (qv_a[gi]),
      .q_rdy (qr_a[gi]),
      .occ   (occ_w)
    );

    assign occ_a[gi] = 32'(occ_w);

    // Items in arrival order; pos_q holds each item's stage. An item advances one
    // stage if any slot ahead of it is free or the output is draining.
    always @(posedge clk or negedge rst_b) begin
      if (!rst_b || clr) begin
        exp_q.delete();
        pos_q.delete();
      end else begin
        out_x = (pos_q.size() > 0) && (pos_q[0] == D - 1) && qr_a[gi];
        in_x  = dv_a[gi] && ((pos_q.size() < D) || qr_a[gi]);
        np.delete();
        for (int k = 0; k < pos_q.size(); k++) begin
          if (qr_a[gi] || (k < D - 1 - pos_q[k])) np.push_back(pos_q[k] + 1);
          else np.push_back(pos_q[k]);
        end
        if (out_x) begin
          void'(np.pop_front());
          void'(exp_q.pop_front());
        end
        pos_q = np;
        if (in_x) begin
          pos_q.push_back(0);
          exp_q.push_back(d_a[gi]);
        end
      end
    end

    always @(negedge clk) begin
      #2;
      exp_qv = !clr && (pos_q.size() > 0) && (pos_q[0] == D - 1);
      exp_dr = !clr && ((pos_q.size() < D) || qr_a[gi]);
      check($sformatf("d%0d_q_vld", D), 32'(qv_a[gi]), 32'(exp_qv));
      check($sformatf("d%0d_d_rdy", D), 32'(dr_a[gi]), 32'(exp_dr));
      if (exp_qv) check($sformatf("d%0d_q", D), 32'(q_a[gi]), 32'(exp_q[0]));
      check($sformatf("d%0d_occ", D), occ_a[gi], 32'(pos_q.size()));
      check($sformatf("d%0d_occ_max", D), 32'(occ_a[gi] <= D), 32'd1);
    end
  end

  task automatic drive(input logic [15:0] dd, input logic dv, input logic qr);
    @(negedge clk);
    d_a[0]  = dd;
    dv_a[0] = dv;
    qr_a[0] = qr;
  endtask

  int pv;
  int pq;

  initial begin
    rst_b = 1'b0;
    clr   = 1'b0;
    for (int g = 0; g < NI; g++) begin
      d_a[g]  = '0;
      dv_a[g] = 1'b0;
      qr_a[g] = 1'b1;
    end
    #2;
    check("rst_q_vld", 32'(qv_a[0]), 32'd0);
    check("rst_q", 32'(q_a[0]), 32'h0000);
    check("rst_occ", occ_a[0], 32'd0);
    check("rst_d_rdy", 32'(dr_a[0]), 32'd1);
    @(negedge clk);
    rst_b = 1'b1;

    // streaming 1..8 with the output always ready
    for (int i = 0; i < 13; i++) begin
      drive(16'(i + 1), i < 8, 1'b1);
      #2;
      if (i >= 4 && i <= 11) begin
        check("stream_q", 32'(q_a[0]), 32'(i - 3));
        check("stream_q_vld", 32'(qv_a[0]), 32'd1);
      end
      if (i >= 4 && i <= 8) check("stream_occ", occ_a[0], 32'd4);
    end
    check("stream_empty", 32'(qv_a[0]), 32'd0);

    // backpressure: fill, try a fifth item, then release
    for (int i = 0; i < 4; i++) drive(16'hA000 + 16'(i), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(16'hA004, 1'b1, 1'b0);
      #2;
      check("bp_occ", occ_a[0], 32'd4);
      check("bp_d_rdy", 32'(dr_a[0]), 32'd0);
      check("bp_q", 32'(q_a[0]), 32'hA000);
    end
    drive(16'hA004, 1'b0, 1'b1);
    #2;
    check("bp_rdy_back", 32'(dr_a[0]), 32'd1);
    check("bp_out0", 32'(q_a[0]), 32'hA000);
    for (int i = 1; i < 4; i++) begin
      drive(16'h0000, 1'b0, 1'b1);
      #2;
      check("bp_out", 32'(q_a[0]), 32'hA000 + 32'(i));
      check("bp_out_vld", 32'(qv_a[0]), 32'd1);
    end
    drive(16'h0000, 1'b0, 1'b1);
    #2;
    check("bp_no_fifth", 32'(qv_a[0]), 32'd0);

    // bubble collapse
    drive(16'h1111, 1'b1, 1'b0);
    drive(16'h0000, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0);
    drive(16'h2222, 1'b1, 1'b0);
    drive(16'h0000, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0);
    #2;
    check("bub_occ", occ_a[0], 32'd2);
    check("bub_q", 32'(q_a[0]), 32'h1111);
    drive(16'h0000, 1'b0, 1'b1);
    #2;
    check("bub_a", 32'(q_a[0]), 32'h1111);
    drive(16'h0000, 1'b0, 1'b1);
    #2;
    check("bub_b", 32'(q_a[0]), 32'h2222);
    check("bub_b_vld", 32'(qv_a[0]), 32'd1);
    drive(16'h0000, 1'b0, 1'b1);
    #2;
    check("bub_empty", 32'(qv_a[0]), 32'd0);

    // flush with three items held and an input presented
    for (int i = 0; i < 3; i++) drive(16'h3333 + 16'(i), 1'b1, 1'b0);
    drive(16'hDEAD, 1'b1, 1'b0);
    clr = 1'b1;
    #2;
    check("clr_d_rdy", 32'(dr_a[0]), 32'd0);
    check("clr_q_vld", 32'(qv_a[0]), 32'd0);
    check("clr_occ_before", occ_a[0], 32'd3);
    drive(16'h0000, 1'b0, 1'b0);
    clr = 1'b0;
    #2;
    check("clr_occ", occ_a[0], 32'd0);
    check("clr_q", 32'(q_a[0]), 32'h0000);
    check("clr_q_vld_after", 32'(qv_a[0]), 32'd0);
    for (int i = 0; i < 5; i++) drive(16'h0000, 1'b0, 1'b1);
    #2;
    check("clr_dropped", 32'(qv_a[0]), 32'd0);

    // asynchronous reset with a full, stalled pipe
    for (int i = 0; i < 4; i++) drive(16'h4444 + 16'(i), 1'b1, 1'b0);
    drive(16'h0000, 1'b0, 1'b0);
    #2;
    check("arst_full", occ_a[0], 32'd4);
    @(posedge clk);
    #3;
    rst_b = 1'b0;
    #1;
    check("arst_q_vld", 32'(qv_a[0]), 32'd0);
    check("arst_q", 32'(q_a[0]), 32'h0000);
    check("arst_occ", occ_a[0], 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    #2;
    check("arst_d_rdy", 32'(dr_a[0]), 32'd1);

    // random traffic on all depths
    pv = 50;
    pq = 50;
    for (int c = 0; c < 10000; c++) begin
      if (c % 1000 == 0) begin
        pv = $urandom_range(20, 95);
        pq = $urandom_range(20, 95);
      end
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        d_a[g]  = 16'($urandom);
        dv_a[g] = $urandom_range(0, 99) < pv;
        qr_a[g] = $urandom_range(0, 99) < pq;
      end
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        dv_a[g] = 1'b0;
        qr_a[g] = 1'b1;
      end
    end
    #2;
    for (int g = 0; g < NI; g++) check($sformatf("drain%0d", g), occ_a[g], 32'd0);

    @(negedge clk);
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgst_pipe.md
Name: rgst_pipe

Overview:
- Parametrised elastic pipeline register: a chain of DEPTH load/clear registers with valid/ready handshaking at both ends.
- Carries operands and intermediate results between CORDIC iteration stages, so a stage can stall without losing data.
- Bubbles collapse: an empty stage is refilled even when the output is stalled.
- Adds a synchronous flush and an occupancy count.

Parameters:
- DW, 16, data width in bits (≥1).
- DEPTH, 4, number of register stages (≥1).
- CLR_VAL, {DW{1'b0}}, value loaded into every data stage on reset and on flush.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_b  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush of all stages.
- d  input  DW  input data.
- d_vld  input  1  input data valid.
- d_rdy  output  1  block can accept d this cycle.
- q  output  DW  output data, equal to stage DEPTH-1 data register.
- q_vld  output  1  q holds a valid item.
- q_rdy  input  1  downstream accepts q this cycle.
- occ  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH.

Behaviour:
- Reset (rst_b=0, asynchronous): all vld[i]=0, all data[i]=CLR_VAL, occ=0. Outputs are then q=CLR_VAL, q_vld=0, d_rdy=1 (when clr=0). Release is synchronous to the next clk edge.
- Stage indexing: stage 0 takes d; stage DEPTH-1 drives q.
- Enable chain (combinational):
  - en[DEPTH-1] = ~vld[DEPTH-1] | q_rdy
  - en[i] = ~vld[i] | en[i+1] for i < DEPTH-1
- Handshake outputs:
  - d_rdy = en[0] & ~clr
  - q_vld = vld[DEPTH-1] & ~clr
- Transfers:
  - Input transfer: d_vld & d_rdy.
  - Output transfer: q_vld & q_rdy.
  - d_vld must not depend on d_rdy; q_rdy may depend on q_vld.
- Stage update when en[i]=1 and clr=0:
  - vld[i] <= incoming valid (stage 0: d_vld; others: vld[i-1]).
  - data[i] <= incoming data only when incoming valid=1; otherwise data[i] holds its old value.
- Stage update when en[i]=0 and clr=0: stage i holds data and valid.
- Latency and throughput:
  - With q_rdy=1 continuously, an item presented at edge k appears on q with q_vld=1 after edge k+DEPTH-1 (DEPTH register stages, first capture at edge k).
  - Throughput is 1 item/cycle.
- Stall: with q_rdy=0 and a full pipe, d_rdy=0 and nothing moves. Bubbles still advance toward the output until the pipe is full.
- occ:
  - Registered; occ <= occ + in_xfer - out_xfer.
  - Must always equal popcount(vld).
  - Never exceeds DEPTH and never underflows.
- clr=1 (synchronous, priority over all transfers):
  - Next edge: all vld=0, all data=CLR_VAL, occ=0.
  - In the clr cycle d_rdy=0 and q_vld=0, so no transfer occurs and any d presented is dropped.
- Simultaneous full-pipe input and output (q_rdy=1, d_vld=1): the whole chain shifts and occ is unchanged.
- DEPTH=1: the block is a single valid-gated register. d_rdy = ~vld[0] | q_rdy.
- Reset mid-stall or mid-stream discards all content immediately, without waiting for a clk edge.
- No X on any output after reset. d is ignored whenever d_vld=0.

Test Plan:
- Reset: assert rst_b=0 mid-cycle with pipe full (occ=4) -> immediately q_vld=0, q=16'h0000, occ=0. After release, d_rdy=1.
- Streaming, DEPTH=4, q_rdy=1: drive d=16'h0001..16'h0008 on 8 consecutive cycles with d_vld=1 -> q=16'h0001 appears with q_vld=1 three edges after its capture. Then one item per cycle in order, occ steady at 4 during the stream.
- Backpressure: q_rdy=0, push 16'hA000..16'hA003 -> occ=4 and d_rdy=0; a fifth d is not accepted. Raise q_rdy -> items exit in order A000..A003 and d_rdy returns to 1 in the same cycle q_rdy rises.
- Bubble collapse: q_rdy=0; push A, idle 2 cycles, push B -> A at stage 3, B packs to stage 2, occ=2, no gaps.
- Flush: pipe holding 3 items, assert clr=1 for one cycle with d_vld=1 -> d_rdy=0 and q_vld=0 in that cycle. Next cycle occ=0, q=CLR_VAL, and the presented d was not captured.
- Randomised d_vld/q_rdy, 10k cycles, with DEPTH=1 and DEPTH=7 -> output sequence equals input sequence, occ always equals popcount(vld), occ ≤ DEPTH.
